// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings and default timing, used by the TX and RX sides.
package uart_pkg;

    localparam int DATA_BITS           = 8;
    localparam int DEFAULT_HALF_PERIOD = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit period timer: latches half_period on start, counts 0..{half_period,1}, pulses bit_end on the last cycle.
// Zero latency from start; the counter only advances while run is high.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int COUNTER_MSB = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   run,
    input  logic [COUNTER_MSB-1:0] half_period,
    output logic                   bit_end
);

    logic [COUNTER_MSB-1:0] hp_q, hp_d;
    logic [COUNTER_MSB:0]   cnt_q, cnt_d;

    always_comb begin
        hp_d    = hp_q;
        cnt_d   = cnt_q;
        bit_end = run && (cnt_q == {hp_q, 1'b1});
        if (start) begin
            hp_d  = half_period;
            cnt_d = '0;
        end else if (run) begin
            cnt_d = bit_end ? '0 : cnt_q + {{COUNTER_MSB{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_q  <= '0;
            cnt_q <= '0;
        end else begin
            hp_q  <= hp_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first with a one-byte holding register; TXD goes low one cycle after accept from idle.
// tx_ready drops while the holding register is full; UART_TX_PARITY_EN adds an even-parity bit before stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int COUNTER_MSB = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COUNTER_MSB-1:0] halfPeriod,
    input  logic [DATA_BITS-1:0]   tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   TXD,
    output logic                   tx_busy,
    output logic                   tx_done
);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 txd_q, txd_d;
    logic                 load;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign tx_ready = ~hold_full_q;
    assign TXD      = txd_q;
    assign tx_busy  = (state_q != IDLE);
    assign tx_done  = (state_q == STOP) && bit_end;

    uart_bit_timer #(.COUNTER_MSB(COUNTER_MSB)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .start       (load),
        .run         (tx_busy),
        .half_period (halfPeriod),
        .bit_end     (bit_end)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        txd_d       = txd_q;
        load        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (hold_full_q) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    txd_d     = shift_q[1];
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                // A byte already held restarts with no idle gap.
                if (bit_end) begin
                    if (hold_full_q) load = 1'b1;
                    else             state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        if (load) begin
            state_d     = START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            txd_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d    = ^hold_q;
`endif
        end

        // Accept and load are exclusive: one needs hold_full low, the other high.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            txd_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            txd_q       <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of single frames from idle, then hand sequences for back-to-back, backpressure, stop-edge accept and reset.
module tb_uart_tx;

    localparam int CM = 9;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CM-1:0] halfPeriod;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          TXD;
    logic          tx_busy;
    logic          tx_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]    data;
        logic [CM-1:0] hp;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_tx #(.COUNTER_MSB(CM)) dut (
        .clk        (clk),
        .rst        (rst),
        .halfPeriod (halfPeriod),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .TXD        (TXD),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == NBITS - 1) return 1'b1;
        return ^d;
    endfunction

    // Entered #1 after the edge that starts the start bit; returns #1 after the edge that ends the stop bit.
    task automatic check_frame(input logic [7:0] d, input int hp, input string nm);
        int bl = 2 * hp + 2;
        int busy_bad = 0;
        int done_cnt = 0;
        logic done_last = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
            int bad = 0;
            for (int c = 0; c < bl; c++) begin
                if (TXD !== exp_bit(d, b)) bad++;
                if (tx_busy !== 1'b1) busy_bad++;
                if (tx_done === 1'b1) done_cnt++;
                if (b == NBITS - 1 && c == bl - 1) done_last = tx_done;
                cyc();
            end
            check($sformatf("%s_bit%0d", nm, b), bad, 0);
        end
        check({nm, "_busy"}, busy_bad, 0);
        check({nm, "_done_count"}, done_cnt, 1);
        check({nm, "_done_last"}, done_last, 1'b1);
    endtask

    // Sends from idle; returns #1 after the edge where the start bit begins.
    task automatic send_idle(input logic [7:0] d, input string nm);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        check({nm, "_ready_low"}, tx_ready, 1'b0);
        check({nm, "_txd_pre"}, TXD, 1'b1);
        cyc();
        check({nm, "_start"}, TXD, 1'b0);
    endtask

    task automatic check_idle(input int n, input string nm);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (TXD !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) bad++;
            cyc();
        end
        check({nm, "_idle"}, bad, 0);
    endtask

    initial begin
        vecs[0] = '{8'h55, 9'd4};
        vecs[1] = '{8'h00, 9'd4};
        vecs[2] = '{8'hFF, 9'd0};
        vecs[3] = '{8'hA5, 9'd1};
        vecs[4] = '{8'h80, 9'd2};
        vecs[5] = '{8'h3C, 9'd0};

        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        halfPeriod = 9'd4;
        #1;
        check("reset_txd", TXD, 1'b1);
        check("reset_ready", tx_ready, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_done", tx_done, 1'b0);
        #21;
        rst = 1'b0;
        cyc();
        cyc();

        for (int i = 0; i < 6; i++) begin
            string nm = $sformatf("vec%0d", i);
            halfPeriod = vecs[i].hp;
            send_idle(vecs[i].data, nm);
            check_frame(vecs[i].data, int'(vecs[i].hp), nm);
            check_idle(3, nm);
        end

        // Back-to-back: second byte queued mid-frame starts right after the first stop bit.
        halfPeriod = 9'd4;
        send_idle(8'hA5, "b2b");
        fork
            check_frame(8'hA5, 4, "b2b_f1");
            begin
                repeat (30) cyc();
                tx_data  = 8'h3C;
                tx_valid = 1'b1;
                cyc();
                tx_valid = 1'b0;
                check("b2b_ready_held", tx_ready, 1'b0);
            end
        join
        check("b2b_ready_after_load", tx_ready, 1'b1);
        check("b2b_second_start", TXD, 1'b0);
        check_frame(8'h3C, 4, "b2b_f2");
        check_idle(3, "b2b");

        // Backpressure: tx_valid held high, only bytes seen while ready are sent.
        halfPeriod = 9'd0;
        fork
            begin
                tx_valid = 1'b1;
                tx_data  = 8'h11;
                cyc();
                tx_data = 8'h22;
                repeat (2) cyc();
                tx_data = 8'h33;
                repeat (20) cyc();
                tx_valid = 1'b0;
            end
            begin
                cyc();
                cyc();
                check_frame(8'h11, 0, "bp_f1");
                check_frame(8'h22, 0, "bp_f2");
                check_frame(8'h33, 0, "bp_f3");
                check_idle(30, "bp");
            end
        join

        // Accept on the stop bit's last cycle: one idle cycle, then the byte with the new halfPeriod.
        halfPeriod = 9'd4;
        send_idle(8'h0F, "sa");
        fork
            check_frame(8'h0F, 4, "sa_f1");
            begin
                repeat (50) cyc();
                halfPeriod = 9'd1;
                repeat (49) cyc();
                tx_data  = 8'h5A;
                tx_valid = 1'b1;
                cyc();
                tx_valid = 1'b0;
            end
        join
        check("sa_gap_txd", TXD, 1'b1);
        check("sa_gap_busy", tx_busy, 1'b0);
        check("sa_gap_ready", tx_ready, 1'b0);
        cyc();
        check("sa_start", TXD, 1'b0);
        check_frame(8'h5A, 1, "sa_f2");
        check_idle(3, "sa");

        // Asynchronous reset in data bit 3 of 0xFF.
        halfPeriod = 9'd4;
        send_idle(8'hFF, "rst");
        repeat (43) cyc();
        check("rst_pre_txd", TXD, 1'b1);
        check("rst_pre_busy", tx_busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_txd", TXD, 1'b1);
        check("rst_async_ready", tx_ready, 1'b1);
        check("rst_async_busy", tx_busy, 1'b0);
        check("rst_async_done", tx_done, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        cyc();
        check_idle(30, "rst_after");
        send_idle(8'h81, "rst_new");
        check_frame(8'h81, 4, "rst_new");
        check_idle(3, "rst_new");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
